// File: rtl/up_counter_pkg.sv
// Shared encodings for the up_counter block: control-FSM states and count modes.
package up_counter_pkg;

  // 2'd3 is unused; the FSM recovers from it by returning to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/up_counter_if.sv
// Control/status bundle of the up_counter: commands in, count and status flags out.
interface up_counter_if #(parameter int WIDTH = 4);
  import up_counter_pkg::*;

  // Handshake: there is no valid/ready pair; en, start, stop and load are levels
  // sampled on every rising clk edge, and each cycle they are high counts as one command.
  logic             en;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
  state_t           state;

  modport master (
    output en, start, stop, load, load_val, limit, mode,
    input  count, tc, busy, done, state
  );

  modport slave (
    input  en, start, stop, load, load_val, limit, mode,
    output count, tc, busy, done, state
  );

endinterface

// File: rtl/up_counter.sv
// Loadable, enable-gated up counter with programmable terminal value, start/stop
// control FSM (WRAP or ONESHOT) and a registered one-cycle terminal-count pulse.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  up_counter_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_limit;

  assign at_limit = (count_q == bus.limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority on every edge: load > stop > start > count.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = ST_RUN;
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if (bus.en && at_limit && (bus.mode == MODE_ONESHOT)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: if (bus.start) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy  = (state_q == ST_RUN);
    bus.done  = (state_q == ST_DONE);
    bus.state = state_q;
  end

  // Count datapath. A limit below the current count lets the count roll through
  // all-ones to zero, since only equality with limit ends a pass.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!bus.stop && bus.en) begin
            if (at_limit) begin
              tc_d = 1'b1;
              if (bus.mode == MODE_WRAP) count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_DONE: if (bus.start) count_d = '0;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule
